// File: rtl/pipeline_event_monitor.sv
// pipeline_event_monitor
// Watches the 5-stage datapath debug outputs (WB instruction/PC, stall, flush,
// forwarding selects) and keeps saturating event counters readable through a
// registered select port. Define PIPE_TRACE_FIFO_EN to also build a FIFO trace
// of retired instructions; without it the trace outputs are tied to 0.

module pipeline_event_monitor #(
    parameter int CW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_enable,
    input  logic          i_clear,
    input  logic [31:0]   i_pc_wb,
    input  logic [31:0]   i_instr_wb,
    input  logic          i_stall,
    input  logic          i_flush,
    input  logic [1:0]    i_forwardA,
    input  logic [1:0]    i_forwardB,
    input  logic [2:0]    i_sel,
    output logic [CW-1:0] o_count,
    output logic          o_trace_valid,
    output logic [31:0]   o_trace_pc,
    output logic [31:0]   o_trace_instr,
    input  logic          i_trace_ready,
    output logic          o_trace_overflow
);

    localparam int            NCNT    = 6;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CW'(1);
        end
    endfunction

    logic            retire_s;
    logic [NCNT-1:0] inc_s;
    logic [CW-1:0]   sel_cnt_s;
    logic [CW-1:0]   cnt_r [NCNT];

    // Classify this cycle's events; bubbles (0 and canonical NOP) never retire.
    always_comb begin
        retire_s = (i_instr_wb != 32'h0000_0000) && (i_instr_wb != 32'h0000_0013);
        inc_s    = {(i_forwardB != 2'b00), (i_forwardA != 2'b00), i_flush, i_stall,
                    retire_s, 1'b1};
    end

    // Event counters: clear dominates, counting only while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else if (i_clear) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else if (i_enable) begin
            for (int i = 0; i < NCNT; i++) begin
                if (inc_s[i]) begin
                    cnt_r[i] <= sat_inc(cnt_r[i]);
                end
            end
        end
    end

    // Read mux for the counter selected by i_sel; unused selects read 0.
    always_comb begin
        sel_cnt_s = {CW{1'b0}};
        case (i_sel)
            3'd0:    sel_cnt_s = cnt_r[0];
            3'd1:    sel_cnt_s = cnt_r[1];
            3'd2:    sel_cnt_s = cnt_r[2];
            3'd3:    sel_cnt_s = cnt_r[3];
            3'd4:    sel_cnt_s = cnt_r[4];
            3'd5:    sel_cnt_s = cnt_r[5];
            default: sel_cnt_s = {CW{1'b0}};
        endcase
    end

    // Registered counter read port (one cycle of read latency).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_count <= {CW{1'b0}};
        end else begin
            o_count <= sel_cnt_s;
        end
    end

`ifdef PIPE_TRACE_FIFO_EN

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]  OCC_ZERO = {(AW+1){1'b0}};

    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   occ_r;
    logic          ovf_r;
    logic          push_req_s;
    logic          full_s;
    logic          pop_s;
    logic          do_push_s;
    logic [63:0]   head_s;

    // Push/pop decisions; a full FIFO still accepts a push when it pops too.
    always_comb begin
        push_req_s = i_enable && retire_s;
        full_s     = (occ_r == OCC_FULL);
        pop_s      = (occ_r != OCC_ZERO) && i_trace_ready;
        do_push_s  = push_req_s && (!full_s || pop_s);
    end

    // Trace storage; contents are only observed through the occupancy gate.
    always_ff @(posedge clk) begin
        if (do_push_s && !i_clear) begin
            mem_r[wr_ptr_r] <= {i_pc_wb, i_instr_wb};
        end
    end

    // Pointers, occupancy and sticky overflow; clear empties everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= OCC_ZERO;
            ovf_r    <= 1'b0;
        end else if (i_clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            occ_r    <= OCC_ZERO;
            ovf_r    <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, pop_s})
                2'b10:   occ_r <= occ_r + (AW+1)'(1);
                2'b01:   occ_r <= occ_r - (AW+1)'(1);
                default: occ_r <= occ_r;
            endcase
            if (push_req_s && full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Head entry presented straight from storage, forced to 0 when empty.
    always_comb begin
        if (occ_r != OCC_ZERO) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = 64'h0;
        end
        o_trace_valid    = (occ_r != OCC_ZERO);
        o_trace_pc       = head_s[63:32];
        o_trace_instr    = head_s[31:0];
        o_trace_overflow = ovf_r;
    end

`else

    logic unused_trace_s;

    // Trace path not built: outputs tied off, ready and PC have no consumer.
    always_comb begin
        o_trace_valid    = 1'b0;
        o_trace_pc       = 32'h0;
        o_trace_instr    = 32'h0;
        o_trace_overflow = 1'b0;
        unused_trace_s   = ^{i_trace_ready, i_pc_wb};
    end

`endif

endmodule

// File: tb/tb_pipeline_event_monitor.sv
// Testbench for pipeline_event_monitor (CW=8, DEPTH=4). Directed scenarios
// followed by randomized traffic; a reference model updates on each rising
// edge and queues expected results, a negedge monitor compares them.

module tb_pipeline_event_monitor;

    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int CMAX  = 255;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_enable, i_clear, i_stall, i_flush, i_trace_ready;
    logic [31:0]   i_pc_wb, i_instr_wb;
    logic [1:0]    i_forwardA, i_forwardB;
    logic [2:0]    i_sel;
    logic [CW-1:0] o_count;
    logic          o_trace_valid, o_trace_overflow;
    logic [31:0]   o_trace_pc, o_trace_instr;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          cnt [6];
    int          m_occ = 0;
    bit          m_ovf = 1'b0;
    int          exp_count_q [$];
    logic [63:0] exp_trace_q [$];

    pipeline_event_monitor #(.CW(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_clear(i_clear),
        .i_pc_wb(i_pc_wb), .i_instr_wb(i_instr_wb), .i_stall(i_stall),
        .i_flush(i_flush), .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
        .i_sel(i_sel), .o_count(o_count), .o_trace_valid(o_trace_valid),
        .o_trace_pc(o_trace_pc), .o_trace_instr(o_trace_instr),
        .i_trace_ready(i_trace_ready), .o_trace_overflow(o_trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge and are consumed at the next one.
    task automatic drive(input bit en, input bit clr, input logic [31:0] pc,
                         input logic [31:0] instr, input bit st, input bit fl,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [2:0] sel, input bit rdy);
        @(posedge clk);
        #2;
        i_enable = en; i_clear = clr; i_pc_wb = pc; i_instr_wb = instr;
        i_stall = st; i_flush = fl; i_forwardA = fa; i_forwardB = fb;
        i_sel = sel; i_trace_ready = rdy;
    endtask

    task automatic idle(input logic [2:0] sel, input bit rdy);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, sel, rdy);
    endtask

    task automatic read_sel(input logic [2:0] sel, input int exp, input string name);
        idle(sel, 1'b0);
        idle(sel, 1'b0);
        check(name, o_count, exp);
    endtask

    // Reference model: counters as saturating integers, FIFO as a queue.
    always @(posedge clk) begin
        bit retire;
        bit ev [6];
        bit pop;
        if (reset) begin
            foreach (cnt[k]) cnt[k] = 0;
            m_occ = 0;
            m_ovf = 1'b0;
            exp_trace_q.delete();
            exp_count_q.push_back(-1);
        end else begin
            exp_count_q.push_back(i_clear ? -1 : ((i_sel < 3'd6) ? cnt[i_sel] : 0));
            retire = (i_instr_wb != 32'h0) && (i_instr_wb != NOP);
            if (i_clear) begin
                foreach (cnt[k]) cnt[k] = 0;
                m_occ = 0;
                m_ovf = 1'b0;
                exp_trace_q.delete();
            end else begin
                ev[0] = 1'b1;            ev[1] = retire;
                ev[2] = i_stall;         ev[3] = i_flush;
                ev[4] = (i_forwardA != 0); ev[5] = (i_forwardB != 0);
                if (i_enable) begin
                    foreach (cnt[k]) if (ev[k] && cnt[k] < CMAX) cnt[k]++;
                end
`ifdef PIPE_TRACE_FIFO_EN
                pop = (m_occ > 0) && i_trace_ready;
                if (i_enable && retire) begin
                    if (m_occ == DEPTH && !pop) begin
                        m_ovf = 1'b1;
                    end else begin
                        exp_trace_q.push_back({i_pc_wb, i_instr_wb});
                        m_occ++;
                    end
                end
                if (pop) m_occ--;
`endif
            end
        end
    end

    // Monitor: compare DUT outputs with model expectations away from the edge.
    always @(negedge clk) begin
        int e;
        if (exp_count_q.size() != 0) begin
            e = exp_count_q.pop_front();
            if (!reset && e >= 0) check("o_count", o_count, e);
        end
        if (!reset) begin
            check("trace_valid", o_trace_valid, m_occ != 0);
            check("trace_overflow", o_trace_overflow, m_ovf);
            if (exp_trace_q.size() != 0) begin
                check("trace_pc", o_trace_pc, exp_trace_q[0][63:32]);
                check("trace_instr", o_trace_instr, exp_trace_q[0][31:0]);
                if (o_trace_valid && i_trace_ready) void'(exp_trace_q.pop_front());
            end else begin
                check("trace_pc_empty", o_trace_pc, 32'h0);
                check("trace_instr_empty", o_trace_instr, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] exp_pcs [4];
        logic [31:0] instr;
        int          bias;

        reset = 1'b1;
        i_enable = 1'b0; i_clear = 1'b0; i_pc_wb = 32'h0; i_instr_wb = 32'h0;
        i_stall = 1'b0; i_flush = 1'b0; i_forwardA = 2'd0; i_forwardB = 2'd0;
        i_sel = 3'd0; i_trace_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        check("reset_count", o_count, 0);
        check("reset_valid", o_trace_valid, 0);

        // basic counting
        for (int i = 0; i < 10; i++)
            drive(1'b1, 1'b0, 32'(i * 4), (i % 2 == 0) ? ADDI : NOP, 1'b0, 1'b0,
                  2'd0, 2'd0, 3'd0, 1'b0);
        read_sel(3'd0, 10, "basic_cycles");
        read_sel(3'd1, 5, "basic_retired");

        // flags, then clear together with a retire
        drive(1'b1, 1'b0, 32'h0, NOP, 1'b1, 1'b1, 2'd2, 2'd1, 3'd0, 1'b0);
        read_sel(3'd2, 1, "flag_stall");
        read_sel(3'd3, 1, "flag_flush");
        read_sel(3'd4, 1, "flag_fwdA");
        read_sel(3'd5, 1, "flag_fwdB");
        read_sel(3'd6, 0, "sel6_zero");
        drive(1'b1, 1'b1, 32'h100, ADDI, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        idle(3'd0, 1'b0);
        check("clear_valid", o_trace_valid, 0);
        check("clear_overflow", o_trace_overflow, 0);
        for (int s = 0; s < 6; s++) read_sel(3'(s), 0, "clear_counter");

        // saturation
        for (int i = 0; i < 300; i++)
            drive(1'b1, 1'b0, 32'h0, NOP, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        read_sel(3'd0, CMAX, "saturate_cycles");

`ifdef PIPE_TRACE_FIFO_EN
        // FIFO order and overflow
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            drive(1'b1, 1'b0, 32'(i * 4), ADDI, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        idle(3'd0, 1'b0);
        check("ovf_set", o_trace_overflow, 1);
        for (int i = 0; i < 4; i++) begin
            idle(3'd0, 1'b1);
            check("fifo_order_pc", o_trace_pc, 32'(i * 4));
        end
        idle(3'd0, 1'b0);
        check("fifo_drained", o_trace_valid, 0);

        // full with simultaneous push and pop
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 32'h40 + 32'(i * 4), ADDI, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        drive(1'b1, 1'b0, 32'h20, ADDI, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b1);
        idle(3'd0, 1'b0);
        check("full_pushpop_ovf", o_trace_overflow, 0);
        check("full_pushpop_valid", o_trace_valid, 1);
        exp_pcs = '{32'h44, 32'h48, 32'h4C, 32'h20};
        for (int i = 0; i < 4; i++) begin
            idle(3'd0, 1'b1);
            check("full_pushpop_order", o_trace_pc, exp_pcs[i]);
        end
        idle(3'd0, 1'b0);
        check("full_pushpop_drained", o_trace_valid, 0);
`endif

        // asynchronous reset mid-run
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 32'h80 + 32'(i * 4), ADDI, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 1'b0);
        idle(3'd0, 1'b0);
        check("prereset_count_nonzero", o_count != 0, 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_count", o_count, 0);
        check("async_rst_valid", o_trace_valid, 0);
        check("async_rst_pc", o_trace_pc, 0);
        check("async_rst_instr", o_trace_instr, 0);
        check("async_rst_ovf", o_trace_overflow, 0);
        idle(3'd0, 1'b0);
        reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bias = (i < 750) ? 3 : 8;
            case ($urandom_range(0, 3))
                0:       instr = 32'h0;
                1:       instr = NOP;
                default: instr = $urandom();
            endcase
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0, $urandom(),
                  instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), $urandom_range(0, 9) < bias);
        end
        idle(3'd0, 1'b0);
        idle(3'd0, 1'b0);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
